// File: rtl/i2c_master_if.sv
// i2c_master_if: host request/result and pad drive/sense signals of the I2C master
interface i2c_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_err;
  modport master(input start, addr, rw, wdata, sda_i, output scl_o, sda_o, busy, done, rdata, ack_err);
  modport slave(output start, addr, rw, wdata, sda_i, input scl_o, sda_o, busy, done, rdata, ack_err);
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte single-master I2C transaction engine with open-drain SCL/SDA drive
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input logic clk,
  input logic reset_n,
  i2c_master_if.master bus
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA_WR, DATA_RD, DATA_ACK, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] q;
  logic [2:0] bit_idx;
  logic [7:0] sh, wdata_r, rdata;
  logic rw_r, samp, ack_err, done;
  logic qend, sample, bend, accept, in_bits;
  assign qend = state != IDLE && cnt == CW'(CLK_DIV - 1);
  assign sample = qend && q == 2'd1;
  assign bend = qend && q == 2'd3;
  assign accept = state == IDLE && bus.start;
  assign in_bits = state inside {ADDR, DATA_WR, DATA_RD};
  // state register; reset drops straight back to IDLE with both lines released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: request acceptance in IDLE, otherwise advance only at bit-period ends
  always_comb begin
    state_n = state;
    if (accept) state_n = START;
    else if (bend)
      case (state)
        START:            state_n = ADDR;
        ADDR:             state_n = bit_idx == 3'd7 ? ADDR_ACK : ADDR;
        ADDR_ACK:         state_n = samp ? STOP : rw_r ? DATA_RD : DATA_WR;
        DATA_WR, DATA_RD: state_n = bit_idx == 3'd7 ? DATA_ACK : state;
        DATA_ACK:         state_n = STOP;
        STOP:             state_n = IDLE;
        default:          state_n = state;
      endcase
  end
  // quarter timebase, bit shifter, SDA sampling and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q <= 2'd0;
      bit_idx <= 3'd0;
      sh <= 8'd0;
      wdata_r <= 8'd0;
      rw_r <= 1'b0;
      samp <= 1'b0;
      rdata <= 8'd0;
      ack_err <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= bend && state == STOP;
      if (accept) begin
        cnt <= '0;
        q <= 2'd0;
        bit_idx <= 3'd0;
        sh <= {bus.addr, bus.rw};
        rw_r <= bus.rw;
        wdata_r <= bus.wdata;
        ack_err <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= qend ? '0 : cnt + 1'b1;
        if (qend) q <= q + 2'd1;
        if (sample) begin
          samp <= bus.sda_i;
          if (state == DATA_RD) sh <= {sh[6:0], bus.sda_i};
        end
        if (bend) begin
          bit_idx <= in_bits ? bit_idx + 3'd1 : 3'd0;
          if (state == ADDR || state == DATA_WR) sh <= {sh[6:0], 1'b0};
          if (state == ADDR_ACK) sh <= wdata_r;
          if (samp && (state == ADDR_ACK || (state == DATA_ACK && !rw_r))) ack_err <= 1'b1;
          if (state == DATA_ACK && rw_r) rdata <= sh;
        end
      end
    end
  end
  // line drive: START/STOP hold SCL high around the SDA edge; data slots pulse SCL in Q1-Q2
  always_comb begin
    bus.scl_o = (state == IDLE || state == START) ? 1'b1 : state == STOP ? |q : q[0] ^ q[1];
    bus.sda_o = state == START ? !q[1] : state == STOP ? q[1] : (state == ADDR || state == DATA_WR) ? sh[7] : 1'b1;
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.rdata = rdata;
  assign bus.ack_err = ack_err;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: table-driven transactions against a behavioural I2C slave with a result scoreboard
module tb_i2c_master_ctrl;
  localparam int DIV = 4;
  localparam logic [6:0] SLV = 7'h54;
  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rd_byte;
    logic        data_nack;
    logic        dbl;
    int          nb;
    logic [17:0] bits;
    int          lat;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  i2c_master_if bus();
  i2c_master_ctrl #(.CLK_DIV(DIV)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  vec_t tbl[7];
  vec_t sb[$];
  int nvec = 0, nerr = 0;
  int cyc = 0, t0 = 0, done_cnt = 0, nstops = 0, bc = 0, nobs = 0;
  logic slv_sda = 1'b1, pscl = 1'b1, psda = 1'b1;
  logic [7:0] abyte = 8'd0, rd_byte = 8'd0;
  logic data_nack = 1'b0;
  logic [31:0] obs = 32'd0;
  wire scl_l = bus.scl_o;
  wire sda_l = bus.sda_i;
  assign bus.sda_i = bus.sda_o & slv_sda;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;
  function automatic logic drv(input int b);
    logic m;
    m = abyte[7:1] == SLV;
    if (b == 8) return !m;
    if (b >= 9 && b <= 16) return (m && abyte[0]) ? rd_byte[16-b] : 1'b1;
    if (b == 17) return !(m && !abyte[0] && !data_nack);
    return 1'b1;
  endfunction
  always @(negedge clk) begin
    if (pscl && scl_l && psda && !sda_l) begin
      bc <= 0;
      nobs <= 0;
      obs <= 32'd0;
      slv_sda <= 1'b1;
    end else if (pscl && scl_l && !psda && sda_l) begin
      nstops <= nstops + 1;
      slv_sda <= 1'b1;
    end else if (!pscl && scl_l) begin
      obs <= {obs[30:0], sda_l};
      nobs <= nobs + 1;
      if (bc < 8) abyte <= {abyte[6:0], sda_l};
      bc <= bc + 1;
    end else if (pscl && !scl_l) slv_sda <= drv(bc);
    pscl <= scl_l;
    psda <= sda_l;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic launch(input vec_t v);
    rd_byte = v.rd_byte;
    data_nack = v.data_nack;
    bus.addr = v.addr;
    bus.rw = v.rw;
    bus.wdata = v.wdata;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b0;
    bus.addr = ~v.addr;
    bus.rw = ~v.rw;
    bus.wdata = ~v.wdata;
    sb.push_back(v);
    if (v.dbl) begin
      repeat (40) @(negedge clk);
      bus.addr = 7'h23;
      bus.wdata = 8'h00;
      bus.rw = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask
  task automatic wait_done();
    int n = 0;
    vec_t v;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 2000);
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    v = sb.pop_front();
    chk("latency", 32'(cyc - t0), 32'(v.lat));
    chk("ack_err", 32'(bus.ack_err), 32'(v.err));
    chk("rdata", 32'(bus.rdata), 32'(v.rdata));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("sda_bits", (obs >> 1) & 32'((1 << v.nb) - 1), 32'(v.bits));
    chk("scl_rises", 32'(nobs), 32'(v.nb + 1));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end
  initial begin
    int d0, s0;
    logic hi;
    vec_t v;
    bus.start = 1'b0;
    bus.addr = 7'd0;
    bus.rw = 1'b0;
    bus.wdata = 8'd0;
    tbl[0] = '{7'h54, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 18, {7'h54, 1'b0, 1'b0, 8'hA5, 1'b0}, 80*DIV, 1'b0, 8'h00};
    tbl[1] = '{7'h54, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, 18, {7'h54, 1'b1, 1'b0, 8'h3C, 1'b1}, 80*DIV, 1'b0, 8'h3C};
    tbl[2] = '{7'h23, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 9, {9'd0, 7'h23, 1'b0, 1'b1}, 44*DIV, 1'b1, 8'h3C};
    tbl[3] = '{7'h54, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 18, {7'h54, 1'b0, 1'b0, 8'h5A, 1'b1}, 80*DIV, 1'b1, 8'h3C};
    tbl[4] = '{7'h54, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0, 18, {7'h54, 1'b1, 1'b0, 8'h81, 1'b1}, 80*DIV, 1'b0, 8'h81};
    tbl[5] = '{7'h54, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b1, 18, {7'h54, 1'b0, 1'b0, 8'hC3, 1'b0}, 80*DIV, 1'b0, 8'h81};
    tbl[6] = '{7'h11, 1'b1, 8'h00, 8'hEE, 1'b0, 1'b0, 9, {9'd0, 7'h11, 1'b1, 1'b1}, 44*DIV, 1'b1, 8'h81};
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(bus.scl_o), 32'd1);
    chk("rst_sda", 32'(bus.sda_o), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ack_err", 32'(bus.ack_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      s0 = nstops;
      launch(tbl[i]);
      wait_done();
      d0 = done_cnt;
      @(negedge clk);
      chk("done_width", 32'(bus.done), 32'd0);
      repeat (8) @(negedge clk);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("stop_seen", 32'(nstops - s0), 32'd1);
    end
    d0 = done_cnt;
    launch(tbl[0]);
    while (cyc - t0 < 214) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(bus.scl_o), 32'd1);
    chk("mid_rst_sda", 32'(bus.sda_o), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    launch(tbl[1]);
    wait_done();
    @(negedge clk);
    v = tbl[0];
    v.rdata = 8'h3C;
    launch(v);
    wait_done();
    launch(tbl[1]);
    chk("b2b_scl", 32'(bus.scl_o), 32'd1);
    chk("b2b_sda", 32'(bus.sda_o), 32'd1);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    hi = 1'b1;
    repeat (4*DIV - 1) begin
      @(negedge clk);
      hi &= bus.scl_o;
    end
    chk("b2b_scl_hold", 32'(hi), 32'd1);
    wait_done();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
